// File: rtl/checkpoint_emitter.sv
// Checkpoint emitter: turns per-task completion pulses into single-beat signature writes.
// Optional macro CP_EMIT_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed priority.
module checkpoint_emitter #(
    parameter logic [31:0] SIGNATURE_ADDR  = 32'h00070000,
    parameter logic [31:0] SIGNATURE_TASK1 = 32'hCAFEAAA1,
    parameter logic [31:0] SIGNATURE_TASK2 = 32'hCAFEAAA2,
    parameter logic [31:0] SIGNATURE_TASK3 = 32'hCAFEAAA3,
    parameter logic [31:0] SIGNATURE_TASK4 = 32'hCAFEAAA4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  task_done_i,
    input  logic        cp_ready_i,
    output logic        cp_valid_o,
    output logic [31:0] checkpoint_addr_o,
    output logic [31:0] checkpoint_data_o,
    output logic [3:0]  pending_o,
    output logic        overflow_o,
    output logic [7:0]  drop_cnt_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  pending_q, pending_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic [3:0]  clr;
    logic [3:0]  drop_vec;
    logic        sel_found;
    logic [1:0]  sel_idx;
`ifdef CP_EMIT_ROUND_ROBIN_EN
    logic [1:0]  last_q, last_d;
    logic [1:0]  cand;
`endif

    function automatic logic [31:0] sig_for(input logic [1:0] idx);
        case (idx)
            2'd0:    sig_for = SIGNATURE_TASK1;
            2'd1:    sig_for = SIGNATURE_TASK2;
            2'd2:    sig_for = SIGNATURE_TASK3;
            default: sig_for = SIGNATURE_TASK4;
        endcase
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [3:0] hits);
        logic [8:0] sum;
        logic [2:0] n;
        n   = 3'(hits[0]) + 3'(hits[1]) + 3'(hits[2]) + 3'(hits[3]);
        sum = {1'b0, base} + 9'(n);
        sat_add = sum[8] ? 8'hFF : sum[7:0];
    endfunction

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 2'd0;
`ifdef CP_EMIT_ROUND_ROBIN_EN
        // Search starts at the task after the one issued last.
        cand = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = last_q + 2'(i + 1);
            if (!sel_found && pending_q[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
`else
        for (int i = 3; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = 2'(i);
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        clr     = 4'b0000;
`ifdef CP_EMIT_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_ISSUE: begin
                if (cp_ready_i) begin
                    state_d = ST_GAP;
                    valid_d = 1'b0;
                    addr_d  = 32'h0;
                    data_d  = 32'h0;
                end
            end
            default: begin
                // IDLE and GAP both arbitrate; GAP exists only to force one idle bus cycle.
                state_d = ST_IDLE;
                valid_d = 1'b0;
                addr_d  = 32'h0;
                data_d  = 32'h0;
                if (sel_found) begin
                    state_d      = ST_ISSUE;
                    valid_d      = 1'b1;
                    addr_d       = SIGNATURE_ADDR;
                    data_d       = sig_for(sel_idx);
                    clr[sel_idx] = 1'b1;
`ifdef CP_EMIT_ROUND_ROBIN_EN
                    last_d       = sel_idx;
`endif
                end
            end
        endcase

        // A pulse coinciding with selection re-arms the bit instead of counting as lost.
        drop_vec   = task_done_i & pending_q & ~clr;
        pending_d  = (pending_q & ~clr) | task_done_i;
        overflow_d = overflow_q | (|drop_vec);
        drop_cnt_d = sat_add(drop_cnt_q, drop_vec);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            addr_q     <= 32'h0;
            data_q     <= 32'h0;
            pending_q  <= 4'b0000;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'h00;
`ifdef CP_EMIT_ROUND_ROBIN_EN
            last_q     <= 2'd3;
`endif
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef CP_EMIT_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign cp_valid_o        = valid_q;
    assign checkpoint_addr_o = addr_q;
    assign checkpoint_data_o = data_q;
    assign pending_o         = pending_q;
    assign overflow_o        = overflow_q;
    assign drop_cnt_o        = drop_cnt_q;

endmodule

// File: doc/checkpoint_emitter.md
CHECKPOINT_EMITTER -- requirements
Module: checkpoint_emitter

Interface
REQ-001 Parameter SIGNATURE_ADDR, default 32'h00070000: bus address driven with every signature write.
REQ-002 Parameters SIGNATURE_TASK1..SIGNATURE_TASK4, defaults 32'hCAFEAAA1..32'hCAFEAAA4: data word emitted for task 1..4.
REQ-003 Port clk, input, 1: single clock, all logic on rising edge.
REQ-004 Port rst, input, 1: synchronous, active-low reset.
REQ-005 Port task_done_i, input, 4: bit k-1 is a one-cycle completion pulse from task k.
REQ-006 Port cp_ready_i, input, 1: downstream accepts the current signature write.
REQ-007 Port cp_valid_o, output, 1: a signature write is presented.
REQ-008 Port checkpoint_addr_o, output, 32: write address; SIGNATURE_ADDR while cp_valid_o=1, else 32'h0.
REQ-009 Port checkpoint_data_o, output, 32: write data; selected signature while cp_valid_o=1, else 32'h0.
REQ-010 Port pending_o, output, 4: per-task pending flags.
REQ-011 Port overflow_o, output, 1: sticky, a completion pulse was lost.
REQ-012 Port drop_cnt_o, output, 8: count of lost pulses, saturating at 8'hFF.

Function
REQ-013 Pending bit k sets on the edge after task_done_i[k]=1; it clears when task k is selected for issue.
REQ-014 Pulse on task k while pending[k]=1 and not cleared in that same cycle: pulse dropped, overflow_o set, drop_cnt_o incremented (saturating).
REQ-015 Pulse on task k in the same cycle its pending bit is cleared by selection: pending[k] re-sets, no drop.
REQ-016 FSM states IDLE, ISSUE, GAP; reset state IDLE.
REQ-017 IDLE: any pending bit set -> select one task, load addr/data registers, clear its pending bit, go to ISSUE.
REQ-018 ISSUE: cp_valid_o=1, addr/data held stable; cp_ready_i=1 at the edge completes the transfer -> GAP; otherwise stay in ISSUE.
REQ-019 GAP: exactly one cycle with cp_valid_o=0 and addr/data=0, so consecutive writes are distinct accesses; then behaves as IDLE (selects directly if anything is pending).
REQ-020 Latency: pulse in cycle N with the FSM idle -> cp_valid_o=1 in cycle N+2.
REQ-021 Back-to-back throughput with cp_ready_i held at 1: one signature every 2 cycles.
REQ-022 Default arbitration is fixed priority, task1 highest.
REQ-023 Outputs are fully registered; no combinational path from inputs to outputs.

Reset
REQ-024 rst=0 at a rising edge: FSM to IDLE, cp_valid_o=0, addr/data=0, pending_o=0, overflow_o=0, drop_cnt_o=0.
REQ-025 Reset asserted mid-ISSUE: the write is aborted, cp_valid_o=0 from the next edge, and the in-flight signature is discarded.

Configuration
REQ-026 Macro CP_EMIT_ROUND_ROBIN_EN defined: arbitration is round-robin, searching from the task after the last issued task (task1 first after reset).
REQ-027 Macro CP_EMIT_ROUND_ROBIN_EN undefined: fixed priority per REQ-022.

Verification
REQ-028 task_done_i=4'b0001 in cycle 0, cp_ready_i=1 -> cycle 2: cp_valid_o=1, addr=32'h00070000, data=32'hCAFEAAA1; cycle 3: valid=0, addr=0, data=0.
REQ-029 task_done_i=4'b1111 in one cycle, cp_ready_i=1 -> fixed priority emits AAA1, AAA2, AAA3, AAA4 in cycles 2, 4, 6, 8; overflow_o stays 0.
REQ-030 cp_ready_i=0 for 10 cycles during ISSUE of AAA3 -> valid/addr/data held constant; transfer completes on the first cycle with ready=1.
REQ-031 Three pulses on task2 while it is pending and stalled -> drop_cnt_o=3, overflow_o=1; 300 such drops -> drop_cnt_o=8'hFF.
REQ-032 rst=0 during ISSUE with tasks pending -> all outputs zero after the edge; after release, no write is emitted without a new pulse.
REQ-033 With CP_EMIT_ROUND_ROBIN_EN, repeated pulses on task1 and task3 -> emission alternates AAA1, AAA3, AAA1, AAA3.
